// File: rtl/alu_seq_muldiv.sv
// -----------------------------------------------------------------------------
// alu_seq_muldiv
//   Execute-stage ALU with the base integer operations (1-cycle) and the RV32M
//   multiply/divide/remainder operations computed iteratively (XLEN cycles).
//   Operands are taken on an in_valid/in_ready handshake; the result is held
//   in registers and offered on an out_valid/out_ready handshake.
//
// Parameters
//   XLEN       operand/result width (power of 2, >= 8)
//   EN_MULDIV  1 enables M ops; 0 makes every op[4]=1 code undefined
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake (in_ready only in IDLE)
//   rs1_data, rs2_data   operands A and B
//   alu_op               5-bit operation code
//   out_valid/out_ready  result handshake (out_valid only in DONE)
//   alu_result           registered result
//   zero                 alu_result == 0
//   overflow             signed overflow for add/sub, 0 otherwise
//   busy                 FSM not in IDLE
// -----------------------------------------------------------------------------
module alu_seq_muldiv #(
   parameter int XLEN      = 32,
   parameter bit EN_MULDIV = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      alu_op,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_result,
   output logic            zero,
   output logic            overflow,
   output logic            busy
);

   localparam int SHW = $clog2(XLEN);
   localparam int MSB = XLEN - 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   // Magnitude of a value that is optionally interpreted as signed.
   function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
      return (sgn && v[MSB]) ? -v : v;
   endfunction

   // Sign fix-up and result selection after the last iteration.
   // p holds {hi, lo} of the product, or {remainder, quotient} for divides.
   function automatic logic [XLEN-1:0] finish_res(
      input logic [2:0]        mop,
      input logic [2*XLEN-1:0] p,
      input logic              negq,
      input logic              negr,
      input logic              dz,
      input logic [XLEN-1:0]   rs1
   );
      logic [2*XLEN-1:0] pm;
      logic [XLEN-1:0]   q;
      logic [XLEN-1:0]   r;
      logic [XLEN-1:0]   res;
      pm = negq ? -p : p;
      q  = negq ? -p[XLEN-1:0] : p[XLEN-1:0];
      r  = negr ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
      if (!mop[2]) begin
         res = (mop[1:0] == 2'b00) ? pm[XLEN-1:0] : pm[2*XLEN-1:XLEN];
      end else if (dz) begin
         // divide by zero: quotient all ones, remainder is the dividend
         res = mop[1] ? rs1 : '1;
      end else begin
         res = mop[1] ? r : q;
      end
      return res;
   endfunction

   state_t              state_q, state_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic                ovf_q, ovf_d;
   logic [2:0]          mop_q, mop_d;
   logic [XLEN-1:0]     opa_q, opa_d;
   logic [2*XLEN-1:0]   prod_q, prod_d;
   logic                negq_q, negq_d;
   logic                negr_q, negr_d;
   logic                dz_q, dz_d;
   logic [XLEN-1:0]     rs1_q, rs1_d;
   logic [SHW-1:0]      cnt_q, cnt_d;

   logic signed [XLEN-1:0] rs1_s;
   logic signed [XLEN-1:0] rs2_s;
   logic [SHW-1:0]         shamt;
   logic [XLEN-1:0]        base_res;
   logic                   base_ovf;
   logic                   is_m;
   logic                   sa, sb;
   logic [XLEN-1:0]        ma, mb;

   assign rs1_s = rs1_data;
   assign rs2_s = rs2_data;
   assign shamt = rs2_data[SHW-1:0];

   // ---- base operations (combinational, registered on acceptance) ----
   always_comb begin
      base_res = '0;
      base_ovf = 1'b0;
      case (alu_op)
         5'b00000: begin
            base_res = rs1_data + rs2_data;
            base_ovf = (rs1_data[MSB] == rs2_data[MSB]) && (base_res[MSB] != rs1_data[MSB]);
         end
         5'b00001: begin
            base_res = rs1_data - rs2_data;
            base_ovf = (rs1_data[MSB] != rs2_data[MSB]) && (base_res[MSB] != rs1_data[MSB]);
         end
         5'b00010: base_res[0] = (rs1_s < rs2_s);
         5'b00011: base_res[0] = (rs1_data < rs2_data);
         5'b00100: base_res = rs1_data << shamt;
         5'b00101: base_res = rs1_data ^ rs2_data;
         5'b00110: base_res = rs1_data >> shamt;
         5'b00111: base_res = rs1_s >>> shamt;
         5'b01000: base_res = rs1_data | rs2_data;
         5'b01001: base_res = rs1_data & rs2_data;
         5'b01011: base_res[0] = (rs1_s >= rs2_s);
         default: base_res = '0;
      endcase
   end

   // Operand signedness: mul/mulh/div/rem signed A; mul/mulh/div/rem signed B;
   // mulhsu signed A only; mulhu/divu/remu unsigned.
   assign is_m = EN_MULDIV && (alu_op[4:3] == 2'b10);
   assign sa   = alu_op[2] ? ~alu_op[0] : (alu_op[1:0] != 2'b11);
   assign sb   = alu_op[2] ? ~alu_op[0] : ~alu_op[1];
   assign ma   = mag(rs1_data, sa);
   assign mb   = mag(rs2_data, sb);

   // ---- one iteration step ----
   logic [XLEN:0]       mul_sum;
   logic [2*XLEN-1:0]   mul_nx;
   logic [XLEN:0]       rem_sh;
   logic                rem_ge;
   logic [XLEN-1:0]     rem_sub;
   logic [2*XLEN-1:0]   div_nx;
   logic [2*XLEN-1:0]   step_nx;

   // Shift-add: add multiplicand to the high half when the multiplier LSB is
   // set, then shift {carry, hi, lo} right by one.
   assign mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opa_q} : '0);
   assign mul_nx  = {mul_sum, prod_q[XLEN-1:1]};

   // Restoring divide: shift next dividend bit into the partial remainder and
   // subtract the divisor when it fits. The true difference always fits in
   // XLEN bits, so the low-order subtraction is exact.
   assign rem_sh  = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
   assign rem_ge  = (rem_sh >= {1'b0, opa_q});
   assign rem_sub = rem_sh[XLEN-1:0] - opa_q;
   assign div_nx  = rem_ge ? {rem_sub, prod_q[XLEN-2:0], 1'b1}
                           : {rem_sh[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
   assign step_nx = mop_q[2] ? div_nx : mul_nx;

   // ---- next-state logic ----
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      mop_d    = mop_q;
      opa_d    = opa_q;
      prod_d   = prod_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      dz_d     = dz_q;
      rs1_d    = rs1_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (is_m) begin
                  mop_d  = alu_op[2:0];
                  negq_d = (sa & rs1_data[MSB]) ^ (sb & rs2_data[MSB]);
                  negr_d = sa & rs1_data[MSB];
                  dz_d   = (rs2_data == '0);
                  rs1_d  = rs1_data;
                  cnt_d  = '0;
                  if (alu_op[2]) begin
                     opa_d  = mb;
                     prod_d = {{XLEN{1'b0}}, ma};
                  end else begin
                     opa_d  = ma;
                     prod_d = {{XLEN{1'b0}}, mb};
                  end
                  state_d = CALC;
               end else begin
                  result_d = base_res;
                  ovf_d    = base_ovf;
                  state_d  = DONE;
               end
            end
         end
         CALC: begin
            prod_d = step_nx;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == '1) begin
               result_d = finish_res(mop_q, step_nx, negq_q, negr_q, dz_q, rs1_q);
               ovf_d    = 1'b0;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---- state registers ----
   always_ff @(posedge clk) begin
      mop_q  <= mop_d;
      opa_q  <= opa_d;
      prod_q <= prod_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      dz_q   <= dz_d;
      rs1_q  <= rs1_d;
      cnt_q  <= cnt_d;
      if (rst) begin
         state_q  <= IDLE;
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign busy       = (state_q != IDLE);
   assign alu_result = result_q;
   assign overflow   = ovf_q;
   assign zero       = (result_q == '0);

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_muldiv
//   Directed-vector scoreboard bench for alu_seq_muldiv. Stimulus pushes the
//   hand-computed result into a queue; a monitor pops and compares whenever a
//   result is transferred. Two instances: XLEN=32 with M ops, XLEN=16 without.
// -----------------------------------------------------------------------------
module tb_alu_seq_muldiv;

   localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, SLT = 5'b00010, SLTU = 5'b00011;
   localparam logic [4:0] SLL = 5'b00100, XOR = 5'b00101, SRL = 5'b00110, SRA = 5'b00111;
   localparam logic [4:0] OR_ = 5'b01000, AND_ = 5'b01001, UNDEF = 5'b01010, BGE = 5'b01011;
   localparam logic [4:0] MUL = 5'b10000, MULH = 5'b10001, MULHSU = 5'b10010, MULHU = 5'b10011;
   localparam logic [4:0] DIV = 5'b10100, DIVU = 5'b10101, REM = 5'b10110, REMU = 5'b10111;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] rs1_data, rs2_data, alu_result;
   logic [4:0]  alu_op;
   logic        zero, overflow, busy;

   logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
   logic [15:0] h_rs1_data, h_rs2_data, h_alu_result;
   logic [4:0]  h_alu_op;
   logic        h_zero, h_overflow, h_busy;

   alu_seq_muldiv #(.XLEN(32), .EN_MULDIV(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .alu_op(alu_op),
      .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
      .zero(zero), .overflow(overflow), .busy(busy)
   );

   alu_seq_muldiv #(.XLEN(16), .EN_MULDIV(1'b0)) dut16 (
      .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
      .rs1_data(h_rs1_data), .rs2_data(h_rs2_data), .alu_op(h_alu_op),
      .out_valid(h_out_valid), .out_ready(h_out_ready), .alu_result(h_alu_result),
      .zero(h_zero), .overflow(h_overflow), .busy(h_busy)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [32:0] exp_q[$];
   string       tag_q[$];
   logic [16:0] hexp_q[$];
   string       htag_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Monitors: compare on every transferred result.
   logic [32:0] mon_e;
   string       mon_t;
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_out: got 0x%0h, want no result", alu_result);
         end else begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            chk({mon_t, "_res"},  64'(alu_result), 64'(mon_e[31:0]));
            chk({mon_t, "_ovf"},  64'(overflow),   64'(mon_e[32]));
            chk({mon_t, "_zero"}, 64'(zero),       64'(mon_e[31:0] == 32'd0));
         end
      end
   end

   logic [16:0] hmon_e;
   string       hmon_t;
   always @(negedge clk) begin
      if (!rst && h_out_valid && h_out_ready) begin
         if (hexp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL h_unexpected_out: got 0x%0h, want no result", h_alu_result);
         end else begin
            hmon_e = hexp_q.pop_front();
            hmon_t = htag_q.pop_front();
            chk({hmon_t, "_res"},  64'(h_alu_result), 64'(hmon_e[15:0]));
            chk({hmon_t, "_ovf"},  64'(h_overflow),   64'(hmon_e[16]));
            chk({hmon_t, "_zero"}, 64'(h_zero),       64'(hmon_e[15:0] == 16'd0));
         end
      end
   end

   // Present an op, wait for acceptance, optionally wait for out_valid.
   // lat = number of cycles from acceptance to first out_valid (1 = next cycle).
   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic eo, input string tag,
                        input bit push, input bit wait_out, output int lat);
      int n;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      alu_op   = op;
      rs1_data = a;
      rs2_data = b;
      if (push) begin
         exp_q.push_back({eo, er});
         tag_q.push_back(tag);
      end
      n = 0;
      while (1'b1) begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 100) begin
            chk({tag, "_accept_timeout"}, 64'(in_ready), 64'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rs1_data = $urandom;
      rs2_data = $urandom;
      lat = 0;
      if (wait_out) begin
         while (1'b1) begin
            lat++;
            @(negedge clk);
            if (out_valid) break;
            if (lat > 100) begin
               chk({tag, "_out_timeout"}, 64'(out_valid), 64'd1);
               break;
            end
         end
      end
   endtask

   task automatic issue16(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input logic eo, input string tag, output int lat);
      int n;
      @(posedge clk);
      #1;
      h_in_valid = 1'b1;
      h_alu_op   = op;
      h_rs1_data = a;
      h_rs2_data = b;
      hexp_q.push_back({eo, er});
      htag_q.push_back(tag);
      n = 0;
      while (1'b1) begin
         @(negedge clk);
         if (h_in_ready) break;
         n++;
         if (n > 100) begin
            chk({tag, "_accept_timeout"}, 64'(h_in_ready), 64'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      h_in_valid = 1'b0;
      lat = 0;
      while (1'b1) begin
         lat++;
         @(negedge clk);
         if (h_out_valid) break;
         if (lat > 100) begin
            chk({tag, "_out_timeout"}, 64'(h_out_valid), 64'd1);
            break;
         end
      end
   endtask

   initial begin
      int lat;
      int seen;
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b1; rs1_data = '0; rs2_data = '0; alu_op = '0;
      h_in_valid = 1'b0; h_out_ready = 1'b1; h_rs1_data = '0; h_rs2_data = '0; h_alu_op = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_result",    64'(alu_result), 64'd0);
      chk("rst_overflow",  64'(overflow),  64'd0);
      chk("rst_zero",      64'(zero),      64'd1);

      // Add with overflow and its timing
      issue(ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, "add_ovf", 1, 1, lat);
      chk("add_lat", 64'(lat), 64'd1);
      @(negedge clk);
      chk("add_in_ready_t2", 64'(in_ready), 64'd1);

      // Base operations
      issue(SRA,  32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, "sra", 1, 1, lat);
      chk("sra_lat", 64'(lat), 64'd1);
      issue(SLL,  32'h00000001, 32'h00000024, 32'h00000010, 1'b0, "sll", 1, 1, lat);
      issue(SRL,  32'h80000000, 32'h00000024, 32'h08000000, 1'b0, "srl", 1, 1, lat);
      issue(SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, "sub_ovf", 1, 1, lat);
      issue(SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0, "sub_zero", 1, 1, lat);
      issue(ADD,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1, "add_negovf", 1, 1, lat);
      issue(SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, "slt", 1, 1, lat);
      issue(SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, "sltu", 1, 1, lat);
      issue(BGE,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, "bge_lt", 1, 1, lat);
      issue(BGE,  32'h00000005, 32'h00000005, 32'h00000001, 1'b0, "bge_eq", 1, 1, lat);
      issue(XOR,  32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, "xor", 1, 1, lat);
      issue(OR_,  32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0, "or", 1, 1, lat);
      issue(AND_, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, "and", 1, 1, lat);
      issue(UNDEF, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, "undef", 1, 1, lat);
      chk("undef_lat", 64'(lat), 64'd1);

      // Multiplies
      issue(MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, "mulh", 1, 1, lat);
      chk("mulh_lat", 64'(lat), 64'd33);
      issue(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "mulhu", 1, 1, lat);
      issue(MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, "mul", 1, 1, lat);
      chk("mul_lat", 64'(lat), 64'd33);
      issue(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "mulhsu", 1, 1, lat);
      issue(MUL,    32'h12345678, 32'h00000010, 32'h23456780, 1'b0, "mul_lo", 1, 1, lat);
      issue(MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0, "mulh_minmin", 1, 1, lat);

      // Divides and corners
      issue(DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, "div_ovf", 1, 1, lat);
      chk("div_ovf_lat", 64'(lat), 64'd33);
      issue(REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, "rem_ovf", 1, 1, lat);
      issue(DIVU, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 1'b0, "divu_by0", 1, 1, lat);
      chk("divu_by0_lat", 64'(lat), 64'd33);
      issue(REMU, 32'h00000007, 32'h00000000, 32'h00000007, 1'b0, "remu_by0", 1, 1, lat);
      issue(DIV,  32'h00000007, 32'h00000000, 32'hFFFFFFFF, 1'b0, "div_by0", 1, 1, lat);
      issue(REM,  32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1'b0, "rem_by0", 1, 1, lat);
      issue(DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, "div_neg", 1, 1, lat);
      issue(REM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, "rem_neg", 1, 1, lat);
      issue(DIV,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, "div_negdvs", 1, 1, lat);
      issue(REM,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0, "rem_negdvs", 1, 1, lat);
      issue(DIVU, 32'h00000064, 32'h00000007, 32'h0000000E, 1'b0, "divu", 1, 1, lat);
      issue(REMU, 32'h00000064, 32'h00000007, 32'h00000002, 1'b0, "remu", 1, 1, lat);

      // Backpressure: hold out_ready low, keep a second op pending
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      issue(ADD, 32'h00000003, 32'h00000004, 32'h00000007, 1'b0, "bp_first", 1, 1, lat);
      exp_q.push_back({1'b0, 32'h000000FF});
      tag_q.push_back("bp_second");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         alu_op   = XOR;
         rs1_data = 32'h000000A5;
         rs2_data = 32'h0000005A;
         @(negedge clk);
         chk("bp_out_valid", 64'(out_valid),  64'd1);
         chk("bp_result",    64'(alu_result), 64'h7);
         chk("bp_in_ready",  64'(in_ready),   64'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("bp_accept_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_second_valid", 64'(out_valid), 64'd1);

      // Reset during CALC iteration 10 of a divide
      issue(DIV, 32'h00000064, 32'h00000007, 32'h0, 1'b0, "div_abort", 0, 0, lat);
      repeat (9) @(posedge clk);
      @(negedge clk);
      chk("abort_busy_before", 64'(busy), 64'd1);
      chk("abort_valid_before", 64'(out_valid), 64'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_busy",      64'(busy),      64'd0);
      chk("abort_in_ready",  64'(in_ready),  64'd1);
      chk("abort_result",    64'(alu_result), 64'd0);
      chk("abort_zero",      64'(zero),      64'd1);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("abort_no_output", 64'(seen), 64'd0);

      // XLEN=16, EN_MULDIV=0 instance
      @(negedge clk);
      chk("h_rst_in_ready", 64'(h_in_ready), 64'd1);
      chk("h_rst_result",   64'(h_alu_result), 64'd0);
      issue16(MUL, 16'h0003, 16'h0004, 16'h0000, 1'b0, "h_mul_undef", lat);
      chk("h_mul_undef_lat", 64'(lat), 64'd1);
      issue16(DIV, 16'h0064, 16'h0007, 16'h0000, 1'b0, "h_div_undef", lat);
      chk("h_div_undef_lat", 64'(lat), 64'd1);
      issue16(ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, "h_add_ovf", lat);
      issue16(SRA, 16'h8000, 16'h0014, 16'hF800, 1'b0, "h_sra", lat);
      issue16(SLL, 16'h0001, 16'h0014, 16'h0010, 1'b0, "h_sll", lat);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("queue_empty",   64'(exp_q.size()),  64'd0);
      chk("h_queue_empty", 64'(hexp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
